// File: rtl/mem_wb_stage.sv
// MEM/WB stage: write-back value selection, sub-word load extraction
// and a two-entry skid buffer with valid/ready handshakes on both sides.
module mem_wb_stage #(
    parameter int DATA_W        = 32,
    parameter int ADDR_W        = 5,
    parameter int SRC_W         = 2,
    parameter int ZERO_SUPPRESS = 1,
    parameter int CNT_W         = 32
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            flush,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic [(2**SRC_W)*DATA_W-1:0]    mem_src_data,
    input  logic [SRC_W-1:0]                mem_src_sel,
    input  logic [1:0]                      mem_load_size,
    input  logic                            mem_load_signed,
    input  logic [$clog2(DATA_W/8)-1:0]     mem_addr_lo,
    input  logic                            mem_GPR_we,
    input  logic [ADDR_W-1:0]               mem_GPR_waddr,
    input  logic                            out_ready,
    output logic                            wb_valid,
    output logic                            wb_GPR_we,
    output logic [ADDR_W-1:0]               wb_GPR_waddr,
    output logic [DATA_W-1:0]               wb_GPR_wdata,
    output logic [CNT_W-1:0]                retire_count
);

    localparam int NSRC  = 2**SRC_W;
    localparam int OFF_W = $clog2(DATA_W/8);

    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] waddr;
        logic [DATA_W-1:0] wdata;
    } entry_t;

    typedef enum logic [1:0] {
        EMPTY,
        ONE,
        TWO
    } state_t;

    state_t state, nxt;
    entry_t main_q, skid_q, new_e;

    logic [DATA_W-1:0] dmem, sel_word, wdata_new;
    logic [DATA_W-1:0] byte_ext, half_ext;
    logic [7:0]        byte_v;
    logic [15:0]       half_v;
    logic [OFF_W-1:0]  half_off;
    logic              zero_dst;
    logic              accept, deliver;
    logic              load_main, load_skid, main_from_skid;

    assign dmem     = mem_src_data[DATA_W-1:0];
    assign half_off = mem_addr_lo & ~OFF_W'(1);
    assign byte_v   = dmem[{mem_addr_lo, 3'b000} +: 8];
    assign half_v   = dmem[{half_off, 3'b000} +: 16];
    assign byte_ext = {{(DATA_W-8){mem_load_signed & byte_v[7]}}, byte_v};
    assign half_ext = {{(DATA_W-16){mem_load_signed & half_v[15]}}, half_v};

    always_comb begin
        sel_word = '0;
        for (int i = 0; i < NSRC; i++) begin
            if (mem_src_sel == SRC_W'(i)) begin
                sel_word = mem_src_data[i*DATA_W +: DATA_W];
            end
        end
    end

    // Load size only matters for the DMEM source.
    always_comb begin
        wdata_new = sel_word;
        if (mem_src_sel == '0) begin
            if (mem_load_size[1]) begin
                wdata_new = dmem;
            end else if (mem_load_size[0]) begin
                wdata_new = half_ext;
            end else begin
                wdata_new = byte_ext;
            end
        end
    end

    assign zero_dst    = (ZERO_SUPPRESS != 0) && (mem_GPR_waddr == '0);
    assign new_e.we    = mem_GPR_we & ~zero_dst;
    assign new_e.waddr = mem_GPR_waddr;
    assign new_e.wdata = wdata_new;

    assign wb_valid     = (state != EMPTY);
    assign wb_GPR_we    = wb_valid & main_q.we;
    assign wb_GPR_waddr = main_q.waddr;
    assign wb_GPR_wdata = main_q.wdata;

    assign accept  = in_valid & in_ready;
    assign deliver = wb_valid & out_ready;

    always_comb begin
        nxt            = state;
        load_main      = 1'b0;
        load_skid      = 1'b0;
        main_from_skid = 1'b0;
        if (flush) begin
            nxt = EMPTY;
        end else begin
            unique case (state)
                EMPTY: begin
                    if (accept) begin
                        load_main = 1'b1;
                        nxt       = ONE;
                    end
                end
                ONE: begin
                    if (accept && deliver) begin
                        load_main = 1'b1;
                    end else if (accept) begin
                        load_skid = 1'b1;
                        nxt       = TWO;
                    end else if (deliver) begin
                        nxt = EMPTY;
                    end
                end
                TWO: begin
                    if (deliver) begin
                        main_from_skid = 1'b1;
                        nxt            = ONE;
                    end
                end
                default: nxt = EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= EMPTY;
            main_q       <= '0;
            skid_q       <= '0;
            in_ready     <= 1'b0;
            retire_count <= '0;
        end else begin
            state    <= nxt;
            in_ready <= (nxt != TWO);
            if (load_main) begin
                main_q <= new_e;
            end else if (main_from_skid) begin
                main_q <= skid_q;
            end
            if (load_skid) begin
                skid_q <= new_e;
            end
            // A beat delivered in a flush cycle was already consumed.
            if (deliver && main_q.we) begin
                retire_count <= retire_count + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_mem_wb_stage.sv
// Randomised and directed checks of mem_wb_stage against a queue model.
module tb_mem_wb_stage;

    logic         clk;
    logic         reset;
    logic         flush;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] mem_src_data;
    logic [1:0]   mem_src_sel;
    logic [1:0]   mem_load_size;
    logic         mem_load_signed;
    logic [1:0]   mem_addr_lo;
    logic         mem_GPR_we;
    logic [4:0]   mem_GPR_waddr;
    logic         out_ready;
    logic         wb_valid;
    logic         wb_GPR_we;
    logic [4:0]   wb_GPR_waddr;
    logic [31:0]  wb_GPR_wdata;
    logic [31:0]  retire_count;

    mem_wb_stage dut (
        .clk            (clk),
        .reset          (reset),
        .flush          (flush),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .mem_src_data   (mem_src_data),
        .mem_src_sel    (mem_src_sel),
        .mem_load_size  (mem_load_size),
        .mem_load_signed(mem_load_signed),
        .mem_addr_lo    (mem_addr_lo),
        .mem_GPR_we     (mem_GPR_we),
        .mem_GPR_waddr  (mem_GPR_waddr),
        .out_ready      (out_ready),
        .wb_valid       (wb_valid),
        .wb_GPR_we      (wb_GPR_we),
        .wb_GPR_waddr   (wb_GPR_waddr),
        .wb_GPR_wdata   (wb_GPR_wdata),
        .retire_count   (retire_count)
    );

    typedef struct {
        bit          we;
        logic [4:0]  waddr;
        logic [31:0] wdata;
    } beat_t;

    beat_t       q[$];
    bit          m_ready;
    logic [31:0] m_ret;
    int          total;
    int          bad;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [31:0] ref_wdata(logic [127:0] src, int sel,
                                              int size, bit sgn, int lo);
        logic [31:0] w;
        logic [31:0] v;
        w = 32'(src >> (sel * 32));
        if (sel != 0 || size >= 2) return w;
        if (size == 0) begin
            v = (w >> (lo * 8)) & 32'hFF;
            if (sgn && v >= 128) v = v + 32'hFFFF_FF00;
        end else begin
            v = (w >> ((lo / 2) * 16)) & 32'hFFFF;
            if (sgn && v >= 32768) v = v + 32'hFFFF_0000;
        end
        return v;
    endfunction

    task automatic tick();
        bit    acc;
        bit    del;
        beat_t e;
        acc     = in_valid && m_ready;
        del     = (q.size() > 0) && out_ready;
        e.we    = mem_GPR_we && (mem_GPR_waddr != 5'd0);
        e.waddr = mem_GPR_waddr;
        e.wdata = ref_wdata(mem_src_data, int'(mem_src_sel), int'(mem_load_size),
                            mem_load_signed, int'(mem_addr_lo));
        @(posedge clk);
        if (del) begin
            if (q[0].we) m_ret = m_ret + 1;
            void'(q.pop_front());
        end
        if (flush) q.delete();
        else if (acc) q.push_back(e);
        m_ready = (q.size() != 2);
        #1;
    endtask

    task automatic drive(bit v, int sel, logic [31:0] d, logic [4:0] a, bit we);
        mem_src_data    = {$urandom, $urandom, $urandom, $urandom};
        mem_src_data[sel*32 +: 32] = d;
        in_valid        = v;
        mem_src_sel     = 2'(sel);
        mem_load_size   = 2'b10;
        mem_load_signed = 1'b0;
        mem_addr_lo     = 2'd0;
        mem_GPR_we      = we;
        mem_GPR_waddr   = a;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        #1;
        total++;
        if ({wb_valid, wb_GPR_we, wb_GPR_waddr, wb_GPR_wdata, retire_count, in_ready} !== '0) begin
            bad++;
            $display("FAIL reset_outputs got v=%b we=%b a=%h d=%h rc=%h rdy=%b want all 0",
                     wb_valid, wb_GPR_we, wb_GPR_waddr, wb_GPR_wdata, retire_count, in_ready);
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        tick();
        total++;
        if (in_ready !== 1'b1 || wb_valid !== 1'b0) begin
            bad++;
            $display("FAIL reset_release got rdy=%b v=%b want rdy=1 v=0", in_ready, wb_valid);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp_d;
        out_ready = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            exp_d = 32'h11 * k;
            drive(1'b1, 1, exp_d, 5'(k), 1'b1);
            tick();
            total++;
            if (wb_valid !== 1'b1 || wb_GPR_wdata !== exp_d || in_ready !== 1'b1) begin
                bad++;
                $display("FAIL b2b_beat%0d got v=%b d=%h rdy=%b want v=1 d=%h rdy=1",
                         k, wb_valid, wb_GPR_wdata, in_ready, exp_d);
            end
        end
        in_valid = 1'b0;
        tick();
        total++;
        if (retire_count !== 32'd4 || wb_valid !== 1'b0) begin
            bad++;
            $display("FAIL b2b_retire got rc=%0d v=%b want rc=4 v=0", retire_count, wb_valid);
        end
    endtask

    task automatic test_load_extract();
        logic [1:0]  sz [7] = '{2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01, 2'b01};
        bit          sg [7] = '{1, 1, 1, 1, 0, 1, 0};
        logic [1:0]  lo [7] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd2, 2'd2, 2'd3};
        logic [31:0] ex [7] = '{32'h0000_0001, 32'h0000_007F, 32'hFFFF_FFFF,
                                32'hFFFF_FF80, 32'h0000_00FF, 32'hFFFF_80FF,
                                32'h0000_80FF};
        out_ready = 1'b1;
        for (int i = 0; i < 7; i++) begin
            drive(1'b1, 0, 32'h80FF_7F01, 5'd3, 1'b1);
            mem_load_size   = sz[i];
            mem_load_signed = sg[i];
            mem_addr_lo     = lo[i];
            tick();
            total++;
            if (wb_valid !== 1'b1 || wb_GPR_wdata !== ex[i]) begin
                bad++;
                $display("FAIL load_%0d got v=%b d=%h want v=1 d=%h",
                         i, wb_valid, wb_GPR_wdata, ex[i]);
            end
        end
        in_valid = 1'b0;
        tick();
        total++;
        if (retire_count !== m_ret) begin
            bad++;
            $display("FAIL load_retire got %0d want %0d", retire_count, m_ret);
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] r0;
        r0 = m_ret;
        out_ready = 1'b0;
        drive(1'b1, 2, 32'hAAAA_0001, 5'd7, 1'b1);
        tick();
        drive(1'b1, 3, 32'hBBBB_0002, 5'd8, 1'b1);
        tick();
        total++;
        if (in_ready !== 1'b0 || wb_GPR_wdata !== 32'hAAAA_0001 || wb_GPR_waddr !== 5'd7) begin
            bad++;
            $display("FAIL bp_full got rdy=%b d=%h a=%0d want rdy=0 d=aaaa0001 a=7",
                     in_ready, wb_GPR_wdata, wb_GPR_waddr);
        end
        drive(1'b1, 1, 32'hCCCC_0003, 5'd9, 1'b1);
        tick();
        total++;
        if (in_ready !== 1'b0 || wb_valid !== 1'b1 || wb_GPR_wdata !== 32'hAAAA_0001) begin
            bad++;
            $display("FAIL bp_hold got rdy=%b v=%b d=%h want rdy=0 v=1 d=aaaa0001",
                     in_ready, wb_valid, wb_GPR_wdata);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        total++;
        if (in_ready !== 1'b1 || wb_valid !== 1'b1 || wb_GPR_wdata !== 32'hBBBB_0002) begin
            bad++;
            $display("FAIL bp_drain got rdy=%b v=%b d=%h want rdy=1 v=1 d=bbbb0002",
                     in_ready, wb_valid, wb_GPR_wdata);
        end
        tick();
        total++;
        if (wb_valid !== 1'b0 || retire_count !== r0 + 32'd2) begin
            bad++;
            $display("FAIL bp_done got v=%b rc=%0d want v=0 rc=%0d",
                     wb_valid, retire_count, r0 + 32'd2);
        end
    endtask

    task automatic test_zero_suppress();
        logic [31:0] r0;
        r0 = m_ret;
        out_ready = 1'b0;
        drive(1'b1, 1, 32'hDEAD_BEEF, 5'd0, 1'b1);
        tick();
        total++;
        if (wb_valid !== 1'b1 || wb_GPR_we !== 1'b0 || wb_GPR_wdata !== 32'hDEAD_BEEF) begin
            bad++;
            $display("FAIL zero_we got v=%b we=%b d=%h want v=1 we=0 d=deadbeef",
                     wb_valid, wb_GPR_we, wb_GPR_wdata);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        total++;
        if (retire_count !== r0 || wb_valid !== 1'b0) begin
            bad++;
            $display("FAIL zero_retire got rc=%0d v=%b want rc=%0d v=0",
                     retire_count, wb_valid, r0);
        end
    endtask

    task automatic test_flush();
        out_ready = 1'b0;
        drive(1'b1, 1, 32'h0000_00A1, 5'd4, 1'b1);
        tick();
        drive(1'b1, 1, 32'h0000_00B2, 5'd5, 1'b1);
        tick();
        drive(1'b1, 1, 32'h0000_00C3, 5'd6, 1'b1);
        flush = 1'b1;
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        total++;
        if (wb_valid !== 1'b0 || in_ready !== 1'b1 || wb_GPR_we !== 1'b0) begin
            bad++;
            $display("FAIL flush_empty got v=%b rdy=%b we=%b want v=0 rdy=1 we=0",
                     wb_valid, in_ready, wb_GPR_we);
        end
        out_ready = 1'b1;
        drive(1'b1, 2, 32'h0000_0055, 5'd10, 1'b1);
        tick();
        total++;
        if (wb_valid !== 1'b1 || wb_GPR_wdata !== 32'h55 || wb_GPR_waddr !== 5'd10) begin
            bad++;
            $display("FAIL flush_next got v=%b d=%h a=%0d want v=1 d=55 a=10",
                     wb_valid, wb_GPR_wdata, wb_GPR_waddr);
        end
        in_valid = 1'b0;
        tick();
        total++;
        if (wb_valid !== 1'b0) begin
            bad++;
            $display("FAIL flush_alone got v=%b want 0", wb_valid);
        end
    endtask

    task automatic test_random();
        bit          ev;
        beat_t       h;
        for (int c = 0; c < 400; c++) begin
            in_valid        = ($urandom_range(0, 3) != 0);
            out_ready       = ($urandom_range(0, 2) != 0);
            flush           = ($urandom_range(0, 15) == 0);
            mem_src_data    = {$urandom, $urandom, $urandom, $urandom};
            mem_src_sel     = 2'($urandom_range(0, 3));
            mem_load_size   = 2'($urandom_range(0, 3));
            mem_load_signed = 1'($urandom_range(0, 1));
            mem_addr_lo     = 2'($urandom_range(0, 3));
            mem_GPR_we      = ($urandom_range(0, 4) != 0);
            mem_GPR_waddr   = 5'($urandom_range(0, 31));
            ev = (q.size() > 0);
            total++;
            if (wb_valid !== ev || in_ready !== m_ready || retire_count !== m_ret) begin
                bad++;
                $display("FAIL rnd_ctl c=%0d got v=%b rdy=%b rc=%0d want v=%b rdy=%b rc=%0d",
                         c, wb_valid, in_ready, retire_count, ev, m_ready, m_ret);
            end
            total++;
            if (wb_GPR_we !== (ev && q[0].we)) begin
                bad++;
                $display("FAIL rnd_we c=%0d got %b want %b", c, wb_GPR_we, ev && q[0].we);
            end
            if (ev) begin
                h = q[0];
                total++;
                if (wb_GPR_wdata !== h.wdata || wb_GPR_waddr !== h.waddr) begin
                    bad++;
                    $display("FAIL rnd_data c=%0d got a=%0d d=%h want a=%0d d=%h",
                             c, wb_GPR_waddr, wb_GPR_wdata, h.waddr, h.wdata);
                end
            end
            tick();
        end
        flush    = 1'b0;
        in_valid = 1'b0;
    endtask

    task automatic test_reset_mid();
        flush     = 1'b1;
        tick();
        flush     = 1'b0;
        out_ready = 1'b0;
        drive(1'b1, 1, 32'h0000_1111, 5'd1, 1'b1);
        tick();
        drive(1'b1, 1, 32'h0000_2222, 5'd2, 1'b1);
        tick();
        reset = 1'b1;
        #1;
        q.delete();
        m_ready = 1'b0;
        m_ret   = '0;
        total++;
        if ({wb_valid, wb_GPR_we, wb_GPR_waddr, wb_GPR_wdata, retire_count, in_ready} !== '0) begin
            bad++;
            $display("FAIL rst_mid got v=%b we=%b a=%h d=%h rc=%h rdy=%b want all 0",
                     wb_valid, wb_GPR_we, wb_GPR_waddr, wb_GPR_wdata, retire_count, in_ready);
        end
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        tick();
        out_ready = 1'b1;
        drive(1'b1, 1, 32'h0000_0077, 5'd3, 1'b1);
        tick();
        total++;
        if (wb_valid !== 1'b1 || wb_GPR_wdata !== 32'h77) begin
            bad++;
            $display("FAIL rst_mid_flow got v=%b d=%h want v=1 d=77", wb_valid, wb_GPR_wdata);
        end
        in_valid = 1'b0;
        tick();
        total++;
        if (retire_count !== 32'd1 || wb_valid !== 1'b0) begin
            bad++;
            $display("FAIL rst_mid_retire got rc=%0d v=%b want rc=1 v=0",
                     retire_count, wb_valid);
        end
    endtask

    initial begin
        total     = 0;
        bad       = 0;
        m_ready   = 1'b0;
        m_ret     = '0;
        reset     = 1'b1;
        flush     = 1'b0;
        out_ready = 1'b0;
        drive(1'b0, 0, 32'h0, 5'd0, 1'b0);
        test_reset();
        test_back_to_back();
        test_load_extract();
        test_backpressure();
        test_zero_suppress();
        test_flush();
        test_random();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
